// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
// Conditions four raw push-buttons for the game datapath: synchronizes them,
// debounces press and release, and turns each accepted press into a single
// registered one-hot code plus a one-cycle pulse.
//
// Ports
//   clock         : system clock, rising edge active
//   reset         : asynchronous, active-low reset
//   habilita      : new presses are accepted only while high
//   botoes[3:0]   : raw asynchronous button levels (1 = pressed)
//   jogada[3:0]   : last accepted one-hot button code (holds until next one)
//   jogada_feita  : one-cycle pulse when jogada is updated
//   tem_jogada    : high while a registered press is held / being released
//   erro_multiplo : one-cycle pulse when a filtered press is not one-hot
//   db_estado[2:0]: current FSM state code (debug)
// -----------------------------------------------------------------------------
module condicionador_botoes #(
   parameter int unsigned DEBOUNCE_CICLOS = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] botoes,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       tem_jogada,
   output logic       erro_multiplo,
   output logic [2:0] db_estado
);

   typedef enum logic [2:0] {
      OCIOSO         = 3'd0,
      FILTRA_PRESS   = 3'd1,
      REGISTRA       = 3'd2,
      ESPERA_SOLTAR  = 3'd3,
      FILTRA_SOLTURA = 3'd4
   } estado_t;

   localparam logic [7:0] LIMITE = 8'(DEBOUNCE_CICLOS);

   // True when exactly one bit of the sample is set.
   function automatic logic e_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   logic [3:0] sinc1_r;
   logic [3:0] sinc_r;
   estado_t    estado_r;
   estado_t    estado_s;
   logic [3:0] amostra_r;
   logic [3:0] amostra_s;
   logic [7:0] contador_r;
   logic [7:0] contador_s;
   logic [7:0] cont_inc_s;
   logic [3:0] jogada_r;
   logic [3:0] jogada_s;
   logic       feita_r;
   logic       feita_s;
   logic       erro_r;
   logic       erro_s;
   logic       tem_r;
   logic       tem_s;

   // Saturating increment: the counter sticks at 255 instead of wrapping.
   assign cont_inc_s = (contador_r == 8'hFF) ? 8'hFF : (contador_r + 8'd1);

   // Two-stage synchronizer for the asynchronous button levels.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc1_r <= 4'd0;
         sinc_r  <= 4'd0;
      end else begin
         sinc1_r <= botoes;
         sinc_r  <= sinc1_r;
      end
   end

   // State, sample, counter and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_r   <= OCIOSO;
         amostra_r  <= 4'd0;
         contador_r <= 8'd0;
         jogada_r   <= 4'd0;
         feita_r    <= 1'b0;
         erro_r     <= 1'b0;
         tem_r      <= 1'b0;
      end else begin
         estado_r   <= estado_s;
         amostra_r  <= amostra_s;
         contador_r <= contador_s;
         jogada_r   <= jogada_s;
         feita_r    <= feita_s;
         erro_r     <= erro_s;
         tem_r      <= tem_s;
      end
   end

   // Next-state and next-output logic. The register/error decision is taken
   // on the edge that enters REGISTRA, so the pulses and the new jogada are
   // visible during the REGISTRA cycle itself.
   always_comb begin
      estado_s   = estado_r;
      amostra_s  = amostra_r;
      contador_s = contador_r;
      jogada_s   = jogada_r;
      feita_s    = 1'b0;
      erro_s     = 1'b0;
      case (estado_r)
         OCIOSO: begin
            if (habilita && (sinc_r != 4'd0)) begin
               amostra_s  = sinc_r;
               contador_s = 8'd0;
               estado_s   = FILTRA_PRESS;
            end else begin
               estado_s   = OCIOSO;
            end
         end
         FILTRA_PRESS: begin
            if (!habilita) begin
               // Press abandoned: wait for release without registering.
               estado_s = ESPERA_SOLTAR;
            end else if (sinc_r == 4'd0) begin
               estado_s = OCIOSO;
            end else if (sinc_r != amostra_r) begin
               amostra_s  = sinc_r;
               contador_s = 8'd0;
            end else begin
               contador_s = cont_inc_s;
               if (cont_inc_s == LIMITE) begin
                  estado_s = REGISTRA;
                  if (e_one_hot(amostra_r)) begin
                     jogada_s = amostra_r;
                     feita_s  = 1'b1;
                  end else begin
                     erro_s   = 1'b1;
                  end
               end else begin
                  estado_s = FILTRA_PRESS;
               end
            end
         end
         REGISTRA: begin
            estado_s = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (sinc_r == 4'd0) begin
               contador_s = 8'd0;
               estado_s   = FILTRA_SOLTURA;
            end else begin
               estado_s   = ESPERA_SOLTAR;
            end
         end
         FILTRA_SOLTURA: begin
            if (sinc_r != 4'd0) begin
               estado_s = ESPERA_SOLTAR;
            end else begin
               contador_s = cont_inc_s;
               if (cont_inc_s == LIMITE) begin
                  estado_s = OCIOSO;
               end else begin
                  estado_s = FILTRA_SOLTURA;
               end
            end
         end
         default: begin
            estado_s = OCIOSO;
         end
      endcase
      tem_s = (estado_s == REGISTRA) || (estado_s == ESPERA_SOLTAR) ||
              (estado_s == FILTRA_SOLTURA);
   end

   assign jogada        = jogada_r;
   assign jogada_feita  = feita_r;
   assign erro_multiplo = erro_r;
   assign tem_jogada    = tem_r;
   assign db_estado     = estado_r;

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

   localparam int D = 2;

   logic       clock    = 1'b0;
   logic       reset    = 1'b0;
   logic       habilita = 1'b0;
   logic [3:0] botoes   = 4'd0;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       tem_jogada;
   logic       erro_multiplo;
   logic [2:0] db_estado;

   condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
      .clock        (clock),
      .reset        (reset),
      .habilita     (habilita),
      .botoes       (botoes),
      .jogada       (jogada),
      .jogada_feita (jogada_feita),
      .tem_jogada   (tem_jogada),
      .erro_multiplo(erro_multiplo),
      .db_estado    (db_estado)
   );

   always #10 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int n_feita = 0;
   int n_erro  = 0;

   task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nome, act, exp);
      end
   endtask

   // One clock: wait for the edge, sample 1 time unit later, count pulses.
   task automatic ciclo();
      @(posedge clock);
      #1;
      if (jogada_feita === 1'b1) n_feita++;
      if (erro_multiplo === 1'b1) n_erro++;
   endtask

   // ---------------- reference model ----------------
   // Modes: 0 idle, 1 filtering a press, 2 press latched (held/releasing).
   int         m_mode;
   logic [3:0] m_val;
   int         m_run;
   logic       m_fresh;
   int         m_zeros;
   logic [3:0] m_jog;
   logic       m_feita;
   logic       m_erro;
   logic [3:0] m_s1;
   logic [3:0] m_s;

   task automatic model_reset();
      m_mode = 0; m_val = 4'd0; m_run = 0; m_fresh = 1'b0; m_zeros = 0;
      m_jog = 4'd0; m_feita = 1'b0; m_erro = 1'b0; m_s1 = 4'd0; m_s = 4'd0;
   endtask

   task automatic model_edge(input logic h, input logic [3:0] b);
      logic [3:0] s;
      s = m_s;
      m_feita = 1'b0;
      m_erro  = 1'b0;
      if (m_mode == 0) begin
         if (h && s != 4'd0) begin m_mode = 1; m_val = s; m_run = 0; end
      end else if (m_mode == 1) begin
         if (!h) begin
            m_mode = 2; m_fresh = 1'b0; m_zeros = 0;
         end else if (s == 4'd0) begin
            m_mode = 0;
         end else if (s != m_val) begin
            m_val = s; m_run = 0;
         end else begin
            m_run++;
            if (m_run == D) begin
               m_mode = 2; m_fresh = 1'b1; m_zeros = 0;
               if ($countones(m_val) == 1) begin m_jog = m_val; m_feita = 1'b1; end
               else m_erro = 1'b1;
            end
         end
      end else begin
         // Latched: the first zero sample only notices the release, then D more.
         if (m_fresh) m_fresh = 1'b0;
         else if (s == 4'd0) begin
            m_zeros++;
            if (m_zeros == D + 1) m_mode = 0;
         end else m_zeros = 0;
      end
      m_s  = m_s1;
      m_s1 = b;
   endtask

   function automatic logic [2:0] model_estado();
      if (m_mode == 0) return 3'd0;
      if (m_mode == 1) return 3'd1;
      if (m_fresh) return 3'd2;
      if (m_zeros == 0) return 3'd3;
      return 3'd4;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic       h;
      logic [3:0] b;
      int         n;
      logic [3:0] jog;
      int         feitas;
      int         erros;
      logic       tem;
      logic [2:0] est;
   } vec_t;

   vec_t tab [15];

   initial begin
      tab[0]  = '{1'b1, 4'b0010,  6, 4'b0010, 1, 0, 1'b1, 3'd3};
      tab[1]  = '{1'b1, 4'b0000,  6, 4'b0010, 0, 0, 1'b0, 3'd0};
      tab[2]  = '{1'b1, 4'b0100, 50, 4'b0100, 1, 0, 1'b1, 3'd3};
      tab[3]  = '{1'b1, 4'b0000,  6, 4'b0100, 0, 0, 1'b0, 3'd0};
      tab[4]  = '{1'b1, 4'b0001,  5, 4'b0001, 1, 0, 1'b1, 3'd2};
      tab[5]  = '{1'b1, 4'b0000,  7, 4'b0001, 0, 0, 1'b0, 3'd0};
      tab[6]  = '{1'b1, 4'b0011, 10, 4'b0001, 0, 1, 1'b1, 3'd3};
      tab[7]  = '{1'b1, 4'b0000,  6, 4'b0001, 0, 0, 1'b0, 3'd0};
      tab[8]  = '{1'b0, 4'b0100,  8, 4'b0001, 0, 0, 1'b0, 3'd0};
      tab[9]  = '{1'b1, 4'b0100,  3, 4'b0100, 1, 0, 1'b1, 3'd2};
      tab[10] = '{1'b1, 4'b0000,  6, 4'b0100, 0, 0, 1'b0, 3'd0};
      tab[11] = '{1'b1, 4'b0010,  3, 4'b0100, 0, 0, 1'b0, 3'd1};
      tab[12] = '{1'b0, 4'b0010,  4, 4'b0100, 0, 0, 1'b1, 3'd3};
      tab[13] = '{1'b0, 4'b0000,  6, 4'b0100, 0, 0, 1'b0, 3'd0};
      tab[14] = '{1'b1, 4'b0000,  2, 4'b0100, 0, 0, 1'b0, 3'd0};

      // Reset state.
      repeat (3) ciclo();
      check("reset_jogada", 32'(jogada), 32'd0);
      check("reset_saidas", 32'({jogada_feita, erro_multiplo, tem_jogada}), 32'd0);
      check("reset_estado", 32'(db_estado), 32'd0);
      reset    = 1'b1;
      habilita = 1'b1;
      repeat (2) ciclo();

      for (int i = 0; i < 15; i++) begin
         n_feita  = 0;
         n_erro   = 0;
         habilita = tab[i].h;
         botoes   = tab[i].b;
         repeat (tab[i].n) ciclo();
         check($sformatf("tab%0d_jogada", i), 32'(jogada), 32'(tab[i].jog));
         check($sformatf("tab%0d_feitas", i), 32'(n_feita), 32'(tab[i].feitas));
         check($sformatf("tab%0d_erros", i), 32'(n_erro), 32'(tab[i].erros));
         check($sformatf("tab%0d_tem", i), 32'(tem_jogada), 32'(tab[i].tem));
         check($sformatf("tab%0d_estado", i), 32'(db_estado), 32'(tab[i].est));
      end

      // Bounce: alternating samples never survive the filter.
      habilita = 1'b1;
      n_feita  = 0;
      for (int i = 0; i < 6; i++) begin
         botoes = (i % 2 == 0) ? 4'b1000 : 4'b0000;
         ciclo();
      end
      check("bounce_sem_pulso", 32'(n_feita), 32'd0);
      botoes = 4'b1000;
      repeat (8) ciclo();
      check("bounce_um_pulso", 32'(n_feita), 32'd1);
      check("bounce_jogada", 32'(jogada), 32'b1000);
      botoes = 4'b0000;
      repeat (6) ciclo();

      // Reset hitting the REGISTRA cycle.
      botoes = 4'b0010;
      repeat (5) ciclo();
      check("registra_pulso", 32'(jogada_feita), 32'd1);
      check("registra_estado", 32'(db_estado), 32'd2);
      reset = 1'b0;
      #1;
      check("reset_imediato", 32'({jogada, jogada_feita, erro_multiplo, tem_jogada, db_estado}), 32'd0);
      botoes = 4'b0000;
      repeat (3) ciclo();
      reset   = 1'b1;
      n_feita = 0;
      repeat (10) ciclo();
      check("pos_reset_sem_pulso", 32'(n_feita), 32'd0);
      check("pos_reset_jogada", 32'(jogada), 32'd0);

      // Reset mid-press with the button still held: a fresh press afterwards.
      botoes = 4'b0100;
      repeat (3) ciclo();
      reset = 1'b0;
      #1;
      check("reset_meio_estado", 32'(db_estado), 32'd0);
      repeat (2) ciclo();
      reset   = 1'b1;
      n_feita = 0;
      repeat (8) ciclo();
      check("reset_meio_nova", 32'(n_feita), 32'd1);
      check("reset_meio_jogada", 32'(jogada), 32'b0100);
      botoes = 4'b0000;
      repeat (6) ciclo();

      // Randomized run against the reference model.
      reset = 1'b0;
      #1;
      model_reset();
      repeat (2) ciclo();
      reset = 1'b1;
      begin
         int cyc;
         cyc = 0;
         while (cyc < 1200) begin
            int         len;
            int         sel;
            logic [3:0] b;
            logic       h;
            sel = int'($urandom_range(0, 3));
            if (sel == 0) b = 4'd0;
            else if (sel == 2) b = 4'($urandom);
            else b = 4'b0001 << $urandom_range(0, 3);
            h   = ($urandom_range(0, 15) != 0);
            len = int'($urandom_range(1, 8));
            habilita = h;
            botoes   = b;
            for (int k = 0; k < len; k++) begin
               ciclo();
               model_edge(h, b);
               check($sformatf("rand_c%0d", cyc),
                     32'({jogada, jogada_feita, erro_multiplo, tem_jogada, db_estado}),
                     32'({m_jog, m_feita, m_erro, (m_mode == 2), model_estado()}));
               cyc++;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
